// File: rtl/pc_unit_if.sv
// pc_unit_if: control/status bundle between the instruction-sequencing logic
// and the program-counter unit.
//   master (sequencer / bench): drives stall, jmp, jsb, ret, reti,
//     branch_taken, target, disp, enai, disi, int_req; observes the status.
//   slave (pc_unit): consumes the controls; drives pc_out, int_ack,
//     int_enable, stack_overflow, stack_underflow.
interface pc_unit_if #(
  parameter int pc_address_width = 12,
  parameter int disp_width       = 8
);
  logic                        stall;
  logic                        jmp;
  logic                        jsb;
  logic                        ret;
  logic                        reti;
  logic                        branch_taken;
  logic [pc_address_width-1:0] target;
  logic [disp_width-1:0]       disp;
  logic                        enai;
  logic                        disi;
  logic                        int_req;
  logic [pc_address_width-1:0] pc_out;
  logic                        int_ack;
  logic                        int_enable;
  logic                        stack_overflow;
  logic                        stack_underflow;

  modport master (
    output stall, jmp, jsb, ret, reti, branch_taken, target, disp,
           enai, disi, int_req,
    input  pc_out, int_ack, int_enable, stack_overflow, stack_underflow
  );

  modport slave (
    input  stall, jmp, jsb, ret, reti, branch_taken, target, disp,
           enai, disi, int_req,
    output pc_out, int_ack, int_enable, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program-counter sequencer feeding the instruction-memory read
// address. Selects the next PC from sequential fetch, absolute jumps,
// subroutine calls/returns, relative branches and interrupt entry; owns the
// return-address stack and the interrupt-enable flag.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - pc_unit_if slave: control inputs in, PC and status out
//           (int_ack is combinational: high in the cycle the interrupt is
//           accepted, PC moves to int_vector on the following edge)
module pc_unit #(
  parameter int pc_address_width = 12,
  parameter int disp_width       = 8,
  parameter int stack_depth      = 8,
  parameter int reset_vector     = 0,
  parameter int int_vector       = 1
) (
  input  logic      clk,
  input  logic      reset,
  pc_unit_if.slave  bus
);
  localparam int SP_W  = $clog2(stack_depth + 1);
  localparam int IDX_W = (stack_depth > 1) ? $clog2(stack_depth) : 1;

  localparam logic [pc_address_width-1:0] PC_ONE  = pc_address_width'(1);
  localparam logic [pc_address_width-1:0] RST_VEC = pc_address_width'(reset_vector);
  localparam logic [pc_address_width-1:0] INT_VEC = pc_address_width'(int_vector);
  localparam logic [SP_W-1:0]             SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0]             SP_ZERO = '0;
  localparam logic [SP_W-1:0]             SP_FULL = SP_W'(stack_depth);

  // Two's-complement displacement widened to PC width.
  function automatic logic [pc_address_width-1:0] sext_disp(
    input logic signed [disp_width-1:0] d
  );
    return {{(pc_address_width-disp_width){d[disp_width-1]}}, d};
  endfunction

  logic [pc_address_width-1:0] pc_q, pc_d;
  logic [SP_W-1:0]             sp_q, sp_d;
  logic                        int_enable_q, int_enable_d;
  logic                        overflow_q, overflow_d;
  logic                        underflow_q, underflow_d;
  logic [pc_address_width-1:0] stack_q [stack_depth];

  logic [pc_address_width-1:0] seq;
  logic [pc_address_width-1:0] branch_pc;
  logic [SP_W-1:0]             sp_m1;
  logic                        xfer;
  logic                        accept;
  logic                        do_push;
  logic                        push_we;
  logic signed [disp_width-1:0] disp_s;

  assign disp_s = bus.disp;

  always_comb begin
    seq       = pc_q + PC_ONE;
    branch_pc = seq + sext_disp(disp_s);
    sp_m1     = sp_q - SP_ONE;
    xfer      = bus.ret | bus.reti | bus.jsb | bus.jmp | bus.branch_taken;
    // Interrupts only slip in on an otherwise sequential cycle, so they never
    // race a control transfer for the stack or the PC.
    accept    = ~bus.stall & int_enable_q & bus.int_req & ~xfer & ~bus.disi;

    pc_d         = pc_q;
    sp_d         = sp_q;
    int_enable_d = int_enable_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    do_push      = 1'b0;
    push_we      = 1'b0;

    if (!bus.stall) begin
      pc_d = seq;
      if (bus.ret || bus.reti) begin
        if (sp_q == SP_ZERO) begin
          underflow_d = 1'b1;
        end else begin
          pc_d = stack_q[sp_m1[IDX_W-1:0]];
          sp_d = sp_m1;
        end
      end else if (bus.jsb) begin
        do_push = 1'b1;
        pc_d    = bus.target;
      end else if (bus.jmp) begin
        pc_d = bus.target;
      end else if (bus.branch_taken) begin
        pc_d = branch_pc;
      end else if (accept) begin
        do_push = 1'b1;
        pc_d    = INT_VEC;
      end

      // A push into a full stack is dropped but the jump still happens.
      if (do_push) begin
        if (sp_q == SP_FULL) begin
          overflow_d = 1'b1;
        end else begin
          push_we = 1'b1;
          sp_d    = sp_q + SP_ONE;
        end
      end

      // disi beats every setter; interrupt entry masks further interrupts.
      if (bus.disi || accept) begin
        int_enable_d = 1'b0;
      end else if (bus.enai || bus.reti) begin
        int_enable_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RST_VEC;
      sp_q         <= SP_ZERO;
      int_enable_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      sp_q         <= sp_d;
      int_enable_q <= int_enable_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Stack storage carries no reset; its contents are only meaningful below sp.
  always_ff @(posedge clk) begin
    if (push_we) begin
      stack_q[sp_q[IDX_W-1:0]] <= seq;
    end
  end

  assign bus.pc_out          = pc_q;
  assign bus.int_ack         = accept;
  assign bus.int_enable      = int_enable_q;
  assign bus.stack_overflow  = overflow_q;
  assign bus.stack_underflow = underflow_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit. Inputs change 1 time
// unit after the rising edge; registered outputs are sampled there too, and
// the combinational int_ack is sampled 1 more unit after the inputs settle.
module tb_pc_unit;
  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  pc_unit_if #(.pc_address_width(12), .disp_width(8)) bus ();

  pc_unit #(
    .pc_address_width(12), .disp_width(8), .stack_depth(8),
    .reset_vector(0), .int_vector(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    bus.stall = 0; bus.jmp = 0; bus.jsb = 0; bus.ret = 0; bus.reti = 0;
    bus.branch_taken = 0; bus.target = '0; bus.disp = '0;
    bus.enai = 0; bus.disi = 0; bus.int_req = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_ctl();
    step(); step();
    n_total++; if (bus.pc_out !== 12'd0) $display("FAIL rst_pc pc_out=%0d exp=0", bus.pc_out); else n_pass++;
    n_total++; if (bus.int_enable !== 1'b0) $display("FAIL rst_ie int_enable=%0b exp=0", bus.int_enable); else n_pass++;
    n_total++; if (bus.int_ack !== 1'b0) $display("FAIL rst_ack int_ack=%0b exp=0", bus.int_ack); else n_pass++;
    n_total++; if ({bus.stack_overflow, bus.stack_underflow} !== 2'b00)
      $display("FAIL rst_flags ovf/unf=%b exp=00", {bus.stack_overflow, bus.stack_underflow}); else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (bus.pc_out !== 12'(i)) $display("FAIL seq_pc pc_out=%0d exp=%0d", bus.pc_out, i); else n_pass++;
      step();
    end
  endtask

  task automatic test_wrap();
    clear_ctl(); bus.jmp = 1; bus.target = 12'd4095;
    step();
    n_total++; if (bus.pc_out !== 12'd4095) $display("FAIL jmp_4095 pc_out=%0d exp=4095", bus.pc_out); else n_pass++;
    clear_ctl();
    step();
    n_total++; if (bus.pc_out !== 12'd0) $display("FAIL wrap pc_out=%0d exp=0", bus.pc_out); else n_pass++;
  endtask

  task automatic test_branch();
    clear_ctl(); bus.jmp = 1; bus.target = 12'd19;
    step();
    clear_ctl(); bus.branch_taken = 1; bus.disp = 8'b11111101;
    step();
    n_total++; if (bus.pc_out !== 12'd17) $display("FAIL br_neg pc_out=%0d exp=17", bus.pc_out); else n_pass++;
    clear_ctl(); bus.jmp = 1; bus.target = 12'd20;
    step();
    clear_ctl(); bus.branch_taken = 1; bus.disp = 8'd4;
    step();
    n_total++; if (bus.pc_out !== 12'd25) $display("FAIL br_pos pc_out=%0d exp=25", bus.pc_out); else n_pass++;
  endtask

  task automatic test_interrupt();
    clear_ctl(); bus.int_req = 1;
    #1;
    n_total++; if (bus.int_ack !== 1'b0) $display("FAIL int_masked int_ack=%0b exp=0", bus.int_ack); else n_pass++;
    step();
    n_total++; if (bus.pc_out !== 12'd26) $display("FAIL int_masked_pc pc_out=%0d exp=26", bus.pc_out); else n_pass++;
    bus.jmp = 1; bus.target = 12'd16;
    step();
    bus.jmp = 0; bus.enai = 1;
    #1;
    n_total++; if (bus.int_ack !== 1'b0) $display("FAIL enai_ack int_ack=%0b exp=0", bus.int_ack); else n_pass++;
    step();
    n_total++; if (bus.pc_out !== 12'd17) $display("FAIL enai_pc pc_out=%0d exp=17", bus.pc_out); else n_pass++;
    n_total++; if (bus.int_enable !== 1'b1) $display("FAIL enai_ie int_enable=%0b exp=1", bus.int_enable); else n_pass++;
    bus.enai = 0;
    #1;
    n_total++; if (bus.int_ack !== 1'b1) $display("FAIL int_ack int_ack=%0b exp=1", bus.int_ack); else n_pass++;
    step();
    n_total++; if (bus.pc_out !== 12'd1) $display("FAIL int_vec pc_out=%0d exp=1", bus.pc_out); else n_pass++;
    n_total++; if (bus.int_enable !== 1'b0) $display("FAIL int_ie int_enable=%0b exp=0", bus.int_enable); else n_pass++;
    n_total++; if (bus.int_ack !== 1'b0) $display("FAIL int_ack_pulse int_ack=%0b exp=0", bus.int_ack); else n_pass++;
    bus.int_req = 0;
    step();
    bus.reti = 1;
    step();
    n_total++; if (bus.pc_out !== 12'd18) $display("FAIL reti_pc pc_out=%0d exp=18", bus.pc_out); else n_pass++;
    n_total++; if (bus.int_enable !== 1'b1) $display("FAIL reti_ie int_enable=%0b exp=1", bus.int_enable); else n_pass++;
    clear_ctl();
  endtask

  task automatic test_jsb();
    clear_ctl(); bus.jmp = 1; bus.target = 12'd26;
    step();
    clear_ctl(); bus.jsb = 1; bus.target = 12'd2;
    step();
    n_total++; if (bus.pc_out !== 12'd2) $display("FAIL jsb_pc pc_out=%0d exp=2", bus.pc_out); else n_pass++;
    clear_ctl();
    step();
    bus.ret = 1;
    step();
    n_total++; if (bus.pc_out !== 12'd27) $display("FAIL ret_pc pc_out=%0d exp=27", bus.pc_out); else n_pass++;
    clear_ctl(); bus.jmp = 1; bus.target = 12'd30;
    step();
    clear_ctl(); bus.jsb = 1; bus.target = 12'd50; bus.int_req = 1;
    #1;
    n_total++; if (bus.int_ack !== 1'b0) $display("FAIL jsb_defer int_ack=%0b exp=0", bus.int_ack); else n_pass++;
    step();
    bus.jsb = 0;
    #1;
    n_total++; if (bus.int_ack !== 1'b1) $display("FAIL defer_ack int_ack=%0b exp=1", bus.int_ack); else n_pass++;
    step();
    n_total++; if (bus.pc_out !== 12'd1) $display("FAIL defer_vec pc_out=%0d exp=1", bus.pc_out); else n_pass++;
    clear_ctl(); bus.reti = 1;
    step();
    n_total++; if (bus.pc_out !== 12'd51) $display("FAIL defer_reti pc_out=%0d exp=51", bus.pc_out); else n_pass++;
    clear_ctl(); bus.ret = 1;
    step();
    n_total++; if (bus.pc_out !== 12'd31) $display("FAIL nested_ret pc_out=%0d exp=31", bus.pc_out); else n_pass++;
    clear_ctl();
  endtask

  task automatic test_stack_limits();
    logic [11:0] exp_pc;
    clear_ctl(); bus.disi = 1;
    step();
    n_total++; if (bus.int_enable !== 1'b0) $display("FAIL disi_ie int_enable=%0b exp=0", bus.int_enable); else n_pass++;
    clear_ctl();
    for (int i = 0; i < 9; i++) begin
      bus.jsb = 1; bus.target = 12'(100 + i);
      step();
      n_total++; if (bus.pc_out !== 12'(100 + i)) $display("FAIL push_pc[%0d] pc_out=%0d exp=%0d", i, bus.pc_out, 100 + i); else n_pass++;
      n_total++; if (bus.stack_overflow !== (i == 8)) $display("FAIL ovf[%0d] stack_overflow=%0b exp=%0b", i, bus.stack_overflow, (i == 8)); else n_pass++;
    end
    clear_ctl();
    // Stack now holds 33, 101..107 (bottom to top); the ninth push was dropped.
    for (int i = 0; i < 8; i++) begin
      bus.ret = 1;
      step();
      exp_pc = (i == 7) ? 12'd33 : 12'(107 - i);
      n_total++; if (bus.pc_out !== exp_pc) $display("FAIL pop_pc[%0d] pc_out=%0d exp=%0d", i, bus.pc_out, exp_pc); else n_pass++;
    end
    clear_ctl(); bus.jmp = 1; bus.target = 12'd40;
    step();
    clear_ctl(); bus.ret = 1;
    step();
    n_total++; if (bus.pc_out !== 12'd41) $display("FAIL unf_pc pc_out=%0d exp=41", bus.pc_out); else n_pass++;
    n_total++; if (bus.stack_underflow !== 1'b1) $display("FAIL unf_flag stack_underflow=%0b exp=1", bus.stack_underflow); else n_pass++;
    n_total++; if (bus.stack_overflow !== 1'b1) $display("FAIL ovf_sticky stack_overflow=%0b exp=1", bus.stack_overflow); else n_pass++;
    clear_ctl();
  endtask

  task automatic test_stall();
    clear_ctl(); bus.enai = 1;
    step();
    n_total++; if (bus.pc_out !== 12'd42) $display("FAIL pre_stall pc_out=%0d exp=42", bus.pc_out); else n_pass++;
    clear_ctl(); bus.stall = 1; bus.jmp = 1; bus.target = 12'd200; bus.int_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (bus.int_ack !== 1'b0) $display("FAIL stall_ack[%0d] int_ack=%0b exp=0", i, bus.int_ack); else n_pass++;
      step();
      n_total++; if (bus.pc_out !== 12'd42) $display("FAIL stall_pc[%0d] pc_out=%0d exp=42", i, bus.pc_out); else n_pass++;
      n_total++; if (bus.int_enable !== 1'b1) $display("FAIL stall_ie[%0d] int_enable=%0b exp=1", i, bus.int_enable); else n_pass++;
    end
    #1;
    reset = 1'b0;
    #1;
    n_total++; if (bus.pc_out !== 12'd0) $display("FAIL async_rst_pc pc_out=%0d exp=0", bus.pc_out); else n_pass++;
    n_total++; if (bus.int_enable !== 1'b0) $display("FAIL async_rst_ie int_enable=%0b exp=0", bus.int_enable); else n_pass++;
    n_total++; if ({bus.stack_overflow, bus.stack_underflow} !== 2'b00)
      $display("FAIL async_rst_flags ovf/unf=%b exp=00", {bus.stack_overflow, bus.stack_underflow}); else n_pass++;
    step();
    clear_ctl();
    reset = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_wrap();
    test_branch();
    test_interrupt();
    test_jsb();
    test_stack_limits();
    test_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
